// File: rtl/if_id_pipe.sv
// ----------------------------------------------------------------------------
// if_id_pipe
// Fetch/decode boundary register with a valid/ready handshake, an optional
// second (skid) entry, flush, and stall selection from a global stall vector.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     fetch-side handshake
//   in_pc, in_inst          fetch-side payload
//   out_valid / out_ready   decode-side handshake
//   out_pc, out_inst        decode-side payload (all-zero while invalid)
//   stall_signal            global stall vector, only bit STALL_BIT is used
//   flush                   drop every held and incoming instruction
//   occupancy               number of held entries (0..2)
//
// SKID=1: two entries, in_ready is a flop output (no path from out_ready/stall).
// SKID=0: one entry, in_ready is combinational so the stage still streams.
// ----------------------------------------------------------------------------
module if_id_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ILEN      = 32,
  parameter int unsigned STALL_LEN = 6,
  parameter int unsigned STALL_BIT = 1,
  parameter int unsigned SKID      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [ILEN-1:0]      in_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [ILEN-1:0]      out_inst,
  input  logic [STALL_LEN-1:0] stall_signal,
  input  logic                 flush,
  output logic [1:0]           occupancy
);

  localparam int unsigned ENTRY_W = XLEN + ILEN;
  localparam bit          SKID_EN = (SKID != 0);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  // Main entry drives the outputs; skid entry absorbs one beat during a stall.
  logic   main_valid_q, main_valid_d;
  entry_t main_q,       main_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t skid_q,       skid_d;

  logic   stall_c;
  logic   acc_c;
  logic   con_c;
  entry_t in_entry_c;

  // Only one bit of the stall vector matters; the rest are intentionally ignored.
  logic   unused_stall_bits;
  assign unused_stall_bits = ^stall_signal;

  assign stall_c    = stall_signal[STALL_BIT];
  assign in_entry_c = '{pc: in_pc, inst: in_inst};
  assign acc_c      = in_valid & in_ready;
  // A stall looks to this stage exactly like the decoder not being ready.
  assign con_c      = main_valid_q & out_ready & ~stall_c;

  // Ready generation differs between the two build options.
  generate
    if (SKID_EN) begin : g_skid_ready
      assign in_ready = ~skid_valid_q;
    end else begin : g_reg_ready
      assign in_ready = ~main_valid_q | con_c;
    end
  endgenerate

  // Next-state selection, highest priority first.
  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;

    if (flush) begin
      // Branch redirect: everything held or offered this cycle is wrong-path.
      main_valid_d = 1'b0;
      main_d       = entry_t'(ENTRY_W'(0));
      skid_valid_d = 1'b0;
      skid_d       = entry_t'(ENTRY_W'(0));
    end else if (!main_valid_q) begin
      if (acc_c) begin
        main_valid_d = 1'b1;
        main_d       = in_entry_c;
      end
    end else if (con_c) begin
      if (skid_valid_q) begin
        // Skid is older than anything fetch can offer (in_ready is low here).
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
        skid_d       = entry_t'(ENTRY_W'(0));
      end else if (acc_c) begin
        main_valid_d = 1'b1;
        main_d       = in_entry_c;
      end else begin
        // Drained with nothing behind it: leave an all-zero bubble.
        main_valid_d = 1'b0;
        main_d       = entry_t'(ENTRY_W'(0));
      end
    end else if (acc_c && SKID_EN) begin
      // Decoder is blocked but in_ready was already high: park the beat.
      skid_valid_d = 1'b1;
      skid_d       = in_entry_c;
    end
  end

  // State registers; reset empties both entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_q       <= entry_t'(ENTRY_W'(0));
      skid_valid_q <= 1'b0;
      skid_q       <= entry_t'(ENTRY_W'(0));
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_pc    = main_q.pc;
  assign out_inst  = main_q.inst;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_if_id_pipe.sv
// ----------------------------------------------------------------------------
// tb_if_id_pipe
// Drives a SKID=1 and a SKID=0 instance from shared inputs and compares both
// against a queue-based reference (capacity 2 or 1 instructions, FIFO order).
// ----------------------------------------------------------------------------
module tb_if_id_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_ready;
  logic [5:0]  stall_signal;
  logic        flush;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] out_pc1, out_inst1, out_pc0, out_inst0;
  logic [1:0]  occ1, occ0;

  int checks = 0;
  int errors = 0;

  ent_t q1[$];
  ent_t q0[$];

  if_id_pipe #(.XLEN(32), .ILEN(32), .STALL_LEN(6), .STALL_BIT(1), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid1), .out_ready(out_ready),
    .out_pc(out_pc1), .out_inst(out_inst1), .stall_signal(stall_signal),
    .flush(flush), .occupancy(occ1)
  );

  if_id_pipe #(.XLEN(32), .ILEN(32), .STALL_LEN(6), .STALL_BIT(1), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid0), .out_ready(out_ready),
    .out_pc(out_pc0), .out_inst(out_inst0), .stall_signal(stall_signal),
    .flush(flush), .occupancy(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ent_t head1();
    ent_t z = '0;
    return (q1.size() > 0) ? q1[0] : z;
  endfunction

  function automatic ent_t head0();
    ent_t z = '0;
    return (q0.size() > 0) ? q0[0] : z;
  endfunction

  function automatic logic exp_rdy1();
    return q1.size() < 2;
  endfunction

  function automatic logic exp_rdy0();
    return (q0.size() == 0) || (out_ready && !stall_signal[1]);
  endfunction

  // Advance the reference by one clock using the inputs currently applied.
  task automatic tick();
    ent_t e;
    bit c1, c0, a1, a0;
    e.pc   = in_pc;
    e.inst = in_inst;
    c1 = (q1.size() > 0) && out_ready && !stall_signal[1];
    c0 = (q0.size() > 0) && out_ready && !stall_signal[1];
    a1 = in_valid && exp_rdy1();
    a0 = in_valid && exp_rdy0();
    if (!rst_n || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (c1) void'(q1.pop_front());
      if (a1) q1.push_back(e);
      if (c0) void'(q0.pop_front());
      if (a0) q0.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b1; stall_signal = '0; flush = 1'b0;
    in_pc = '0; in_inst = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; in_pc = $urandom; in_inst = $urandom;
    out_ready = 1'b1; stall_signal = '0; flush = 1'b0;
    #1;
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid1); end
    checks++; if ({out_pc1, out_inst1} !== 64'h0) begin errors++; $display("FAIL reset_payload: got %h %h exp 0", out_pc1, out_inst1); end
    checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", occ1); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", in_ready1); end
    tick();
    tick();
    checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %b/%b exp 0/0", out_valid1, out_valid0); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_hold_ready: got %b exp 1", in_ready1); end
    rst_n = 1'b1;
    in_valid = 1'b1; in_pc = 32'h1000; in_inst = 32'h00500093;
    tick();
    checks++; if (out_valid1 !== 1'b1 || out_pc1 !== 32'h1000 || out_inst1 !== 32'h00500093)
      begin errors++; $display("FAIL first_out: got %b %h %h exp 1 1000 00500093", out_valid1, out_pc1, out_inst1); end
    checks++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h1000 || out_inst0 !== 32'h00500093)
      begin errors++; $display("FAIL first_out0: got %b %h %h exp 1 1000 00500093", out_valid0, out_pc0, out_inst0); end
    idle();
    tick();
    checks++; if (out_valid1 !== 1'b0 || out_pc1 !== 32'h0 || out_inst1 !== 32'h0)
      begin errors++; $display("FAIL bubble: got %b %h %h exp 0 0 0", out_valid1, out_pc1, out_inst1); end
  endtask

  task automatic test_streaming(input logic [5:0] sv, input logic [31:0] base);
    idle();
    stall_signal = sv;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_pc    = base + 32'(4 * i);
      in_inst  = 32'h13 + 32'(i);
      #1;
      checks++; if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1)
        begin errors++; $display("FAIL stream_ready[%0d]: got %b/%b exp 1/1", i, in_ready1, in_ready0); end
      tick();
      checks++; if (out_valid1 !== 1'b1 || out_pc1 !== base + 32'(4 * i))
        begin errors++; $display("FAIL stream_out[%0d]: got %b %h exp 1 %h", i, out_valid1, out_pc1, base + 32'(4 * i)); end
      checks++; if (out_valid0 !== 1'b1 || out_pc0 !== base + 32'(4 * i))
        begin errors++; $display("FAIL stream_out0[%0d]: got %b %h exp 1 %h", i, out_valid0, out_pc0, base + 32'(4 * i)); end
    end
    idle();
    tick();
    checks++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0)
      begin errors++; $display("FAIL stream_drain: got %b %0d exp 0 0", out_valid1, occ1); end
  endtask

  task automatic fill_two(input logic [31:0] pc_a);
    idle();
    in_valid = 1'b1; in_pc = pc_a; in_inst = pc_a ^ 32'hA5A5_0000;
    tick();
    stall_signal = 6'b000010;
    in_pc = pc_a + 32'h4; in_inst = (pc_a + 32'h4) ^ 32'hA5A5_0000;
    tick();
  endtask

  task automatic test_skid();
    fill_two(32'h100);
    checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL skid_occ: got %0d exp 2", occ1); end
    checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL skid_ready: got %b exp 0", in_ready1); end
    checks++; if (out_pc1 !== 32'h100) begin errors++; $display("FAIL skid_hold: got %h exp 100", out_pc1); end
    in_valid = 1'b0; stall_signal = '0;
    tick();
    checks++; if (out_valid1 !== 1'b1 || out_pc1 !== 32'h104)
      begin errors++; $display("FAIL skid_second: got %b %h exp 1 104", out_valid1, out_pc1); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %b exp 1", in_ready1); end
    tick();
    checks++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0)
      begin errors++; $display("FAIL skid_empty: got %b %0d exp 0 0", out_valid1, occ1); end
  endtask

  task automatic test_flush();
    fill_two(32'h300);
    checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d exp 2", occ1); end
    in_valid = 1'b1; in_pc = 32'h200; in_inst = 32'h0000_0200; flush = 1'b1;
    tick();
    checks++; if (out_valid1 !== 1'b0 || out_pc1 !== 32'h0 || out_inst1 !== 32'h0 || occ1 !== 2'd0)
      begin errors++; $display("FAIL flush_clear: got %b %h %h %0d exp 0 0 0 0", out_valid1, out_pc1, out_inst1, occ1); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", in_ready1); end
    checks++; if (out_valid0 !== 1'b0 || occ0 !== 2'd0)
      begin errors++; $display("FAIL flush_clear0: got %b %0d exp 0 0", out_valid0, occ0); end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid1 !== 1'b0 || out_pc1 === 32'h200)
        begin errors++; $display("FAIL flush_leak[%0d]: got %b %h exp 0", i, out_valid1, out_pc1); end
    end
  endtask

  task automatic test_noskid_ready();
    idle();
    in_valid = 1'b1; in_pc = 32'h400; in_inst = 32'h4400;
    tick();
    in_pc = 32'h404; in_inst = 32'h4404; out_ready = 1'b0;
    #1;
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL noskid_block: got %b exp 0", in_ready0); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL noskid_open: got %b exp 1", in_ready0); end
    tick();
    checks++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h404)
      begin errors++; $display("FAIL noskid_next: got %b %h exp 1 404", out_valid0, out_pc0); end
    idle();
    tick();
  endtask

  task automatic test_reset_midop();
    fill_two(32'h500);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0 || out_pc1 !== 32'h0 || out_inst1 !== 32'h0)
      begin errors++; $display("FAIL async_reset: got %b %0d %h %h exp 0 0 0 0", out_valid1, occ1, out_pc1, out_inst1); end
    checks++; if (in_ready1 !== 1'b1 || out_valid0 !== 1'b0)
      begin errors++; $display("FAIL async_reset_ready: got %b %b exp 1 0", in_ready1, out_valid0); end
    q1.delete();
    q0.delete();
    idle();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    ent_t h;
    for (int i = 0; i < 400; i++) begin
      in_valid     = 1'($urandom_range(0, 3) != 0);
      in_pc        = $urandom;
      in_inst      = $urandom;
      out_ready    = 1'($urandom_range(0, 2) != 0);
      stall_signal = 6'($urandom);
      flush        = 1'($urandom_range(0, 15) == 0);
      #1;
      checks++; if (in_ready1 !== exp_rdy1())
        begin errors++; $display("FAIL rnd_ready1[%0d]: got %b exp %b", i, in_ready1, exp_rdy1()); end
      checks++; if (in_ready0 !== exp_rdy0())
        begin errors++; $display("FAIL rnd_ready0[%0d]: got %b exp %b", i, in_ready0, exp_rdy0()); end
      tick();
      h = head1();
      checks++; if (out_valid1 !== (q1.size() > 0) || out_pc1 !== h.pc || out_inst1 !== h.inst || occ1 !== 2'(q1.size()))
        begin errors++; $display("FAIL rnd_out1[%0d]: got %b %h %h %0d exp %b %h %h %0d", i, out_valid1, out_pc1, out_inst1, occ1, q1.size() > 0, h.pc, h.inst, q1.size()); end
      h = head0();
      checks++; if (out_valid0 !== (q0.size() > 0) || out_pc0 !== h.pc || out_inst0 !== h.inst || occ0 !== 2'(q0.size()))
        begin errors++; $display("FAIL rnd_out0[%0d]: got %b %h %h %0d exp %b %h %h %0d", i, out_valid0, out_pc0, out_inst0, occ0, q0.size() > 0, h.pc, h.inst, q0.size()); end
    end
    idle();
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #1;
    test_reset();
    test_streaming(6'b000000, 32'h0);
    test_skid();
    test_streaming(6'b111101, 32'h40);
    test_flush();
    test_noskid_ready();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Parametrised fetch/decode pipeline boundary register with a valid/ready handshake, a two-entry skid buffer, flush, and per-stage stall selection. It sits between the instruction-fetch stage and the decoder. It carries a PC and an instruction word of configurable widths. It can stall or flush without losing or duplicating an instruction.

## Interface
Parameters:
- `XLEN`, default 32, PC width in bits.
- `ILEN`, default 32, instruction word width in bits.
- `STALL_LEN`, default 6, width of the global stall vector.
- `STALL_BIT`, default 1, index of the stall-vector bit that freezes this stage.
- `SKID`, default 1. 1 selects the two-entry skid buffer with registered `in_ready`. 0 selects a single register with combinational `in_ready`.

Ports:
- `clk`  in  1  Clock; all state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset. One clock; the polarity and synchronicity are fixed.
- `in_valid`  in  1  Fetch presents an instruction.
- `in_ready`  out  1  The stage can accept an instruction this cycle.
- `in_pc`  in  XLEN  PC of the presented instruction.
- `in_inst`  in  ILEN  Presented instruction word.
- `out_valid`  out  1  The decode side holds a valid instruction.
- `out_ready`  in  1  Decode consumes the instruction this cycle.
- `out_pc`  out  XLEN  PC to decode.
- `out_inst`  out  ILEN  Instruction to decode.
- `stall_signal`  in  STALL_LEN  Global stall vector; only bit `STALL_BIT` is used.
- `flush`  in  1  Discard all held and incoming instructions (branch redirect).
- `occupancy`  out  2  Number of held entries, 0 to 2 (0 to 1 when `SKID`=0).

## Operation
- State consists of a main entry, which drives the `out_*` ports, and a skid entry (`SKID`=1 only). Each entry has its own valid bit, PC and instruction.
- Accept: `acc = in_valid & in_ready`.
- Consume: `con = out_valid & out_ready & ~stall_signal[STALL_BIT]`. A stall is equivalent to `out_ready`=0.
- With `SKID`=1, `in_ready = ~skid_valid`. This is registered and has no combinational path from `out_ready` or the stall vector.
- Next-state cases, evaluated in priority order:
  - `flush`: both valid bits clear. The main PC and instruction are zeroed. An input offered in the same cycle is dropped, even if `acc`=1.
  - Main empty, `acc`: input loads into main.
  - Main full, `con`, skid full: skid moves to main and skid clears. No accept is possible in this case.
  - Main full, `con`, skid empty, `acc`: input loads into main.
  - Main full, `con`, no `acc`: main clears and its payload is zeroed to form a bubble.
  - Main full, no `con`, `acc`: input loads into the skid. `in_ready` drops the next cycle.
  - Main full, no `con`, no `acc`: hold.
- With `SKID`=0, `in_ready = ~main_valid | con` (combinational) and the skid entry does not exist.
- `occupancy = main_valid + skid_valid`.
- Ordering: instructions leave in the order they were accepted. No instruction is duplicated or lost except by `flush`.
- While invalid, the `out_pc` and `out_inst` bubble value is all-zero.

## Timing
- Reset (`rst_n`=0, asynchronous assert): `out_valid`=0, `out_pc`=0, `out_inst`=0, skid cleared, `occupancy`=0. With `SKID`=1, `in_ready`=1 during and after reset. Deassertion is synchronous to `clk` externally.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- Latency is 1 cycle: an instruction accepted at edge N appears on `out_*` with `out_valid`=1 after edge N.
- Throughput is 1 instruction per cycle with `out_ready`=1 and no stall, for either `SKID` setting.
- Stall or `out_ready` low while main is full: the `out_*` ports hold stable, and at most one further instruction is absorbed into the skid.
- `flush` takes effect at the next edge and overrides stall, `acc` and `con` in the same cycle. `in_ready` is 1 the cycle after a flush.
- The stall vector is sampled only on bit `STALL_BIT`. Other bits have no effect.

## Test plan
- Reset: hold `rst_n`=0 while `in_valid`=1 with random data → `out_valid`=0, `out_*`=0, `occupancy`=0, `in_ready`=1. Release, then present PC=0x1000, inst=0x00500093 → these appear on `out_*` one cycle later.
- Streaming: present 8 back-to-back instructions with PC 0x0, 0x4, …, 0x1C and `out_ready`=1 → 8 outputs in order, one per cycle, `in_ready` stays 1.
- Skid: main holds 0x100, assert `stall_signal[1]`, accept 0x104 → `occupancy`=2 and `in_ready`=0. Release the stall → 0x100 then 0x104 appear on consecutive cycles, and `in_ready` returns to 1 after the skid drains.
- Stall selectivity: set `stall_signal` = 6'b111101 (bit 1 clear) → no stall, full throughput.
- Flush: with `occupancy`=2 and `in_valid`=1 (PC 0x200), assert `flush` for one cycle → next cycle `out_valid`=0, `out_*`=0, `occupancy`=0. 0x200 never appears on the output.
- `SKID`=0 build: hold `out_ready` low with main full → `in_ready`=0 combinationally. Raise `out_ready` → `in_ready`=1 in the same cycle and the next instruction is accepted.
